// File: rtl/stream_demux_n.sv
// Registered 1:N packet demultiplexer with valid/ready handshakes.
// The channel is chosen at the packet head and held until the last beat; beats for disabled channels are dropped and counted.
module stream_demux_n #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH),
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en_mask,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_last,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic [CNT_W-1:0]  drop_cnt
);

  // Every encodable select value gets a slot, so out-of-range selects read a zero enable.
  localparam int SLOTS = 1 << SEL_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t state, state_d;

  logic [SLOTS-1:0]  en_ext;
  logic [SLOTS-1:0]  rdy_ext;
  logic              head_drop;
  logic              cur_drop;
  logic [SEL_W-1:0]  cur_ch;
  logic              accept;
  logic              drain;

  logic              lock_drop;
  logic [SEL_W-1:0]  lock_ch;

  logic              reg_v;
  logic [SEL_W-1:0]  reg_ch;
  logic [DATA_W-1:0] reg_data;
  logic              reg_last;

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    en_ext               = '0;
    en_ext[NUM_CH-1:0]   = en_mask;
    rdy_ext              = '0;
    rdy_ext[NUM_CH-1:0]  = out_ready;
  end

  assign head_drop = !en_ext[in_sel];
  assign cur_drop  = (state == IDLE) ? head_drop : lock_drop;
  assign cur_ch    = (state == IDLE) ? in_sel : lock_ch;
  assign drain     = reg_v && rdy_ext[reg_ch];
  assign in_ready  = cur_drop || !reg_v || rdy_ext[reg_ch];
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept && !in_last) state_d = LOCKED;
      LOCKED:  if (accept && in_last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Head decisions are frozen here; en_mask and in_sel are ignored until the next head.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_ch   <= '0;
      lock_drop <= 1'b0;
    end else if (state == IDLE && accept && !in_last) begin
      lock_ch   <= in_sel;
      lock_drop <= head_drop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_v    <= 1'b0;
      reg_ch   <= '0;
      reg_data <= '0;
      reg_last <= 1'b0;
    end else if (accept && !cur_drop) begin
      reg_v    <= 1'b1;
      reg_ch   <= cur_ch;
      reg_data <= in_data;
      reg_last <= in_last;
    end else if (drain) begin
      reg_v    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                           drop_cnt <= '0;
    else if (accept && cur_drop && drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + 1'b1;
  end

  always_comb begin
    out_valid = '0;
    for (int i = 0; i < NUM_CH; i++) out_valid[i] = reg_v && (reg_ch == SEL_W'(i));
  end

  assign out_data = reg_data;
  assign out_last = reg_last;
  assign busy     = (state == LOCKED);

endmodule

// File: tb/tb_stream_demux_n.sv
// Directed bench for stream_demux_n: a 4-channel instance for routing, lock, backpressure, drop and reset,
// plus a 3-channel instance with a 2-bit counter for out-of-range selects and counter saturation.
module tb_stream_demux_n;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] en_mask;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_sel;
  logic       in_last;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic [15:0] drop_cnt;

  logic       in_valid3;
  logic       in_ready3;
  logic [2:0] out_valid3;
  logic [7:0] out_data3;
  logic       out_last3;
  logic       busy3;
  logic [1:0] drop_cnt3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stream_demux_n #(.DATA_W(8), .NUM_CH(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .en_mask(en_mask),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  stream_demux_n #(.DATA_W(8), .NUM_CH(3), .CNT_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .en_mask(3'b111),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
    .out_valid(out_valid3), .out_ready(3'b111), .out_data(out_data3), .out_last(out_last3),
    .busy(busy3), .drop_cnt(drop_cnt3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] pat;
  int n_sent, n_recv, cyc;
  logic acc;

  initial begin
    rst = 1'b1; en_mask = 4'hF; out_ready = 4'hF;
    in_valid = 1'b0; in_valid3 = 1'b0; in_data = '0; in_sel = '0; in_last = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data",  32'(out_data),  32'h0);
    check("rst_out_last",  32'(out_last),  32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_drop_cnt",  32'(drop_cnt),  32'h0);
    check("rst_drop_cnt3", 32'(drop_cnt3), 32'h0);

    // Back-to-back single-beat packets to each channel.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_sel = 2'(i); in_data = 8'(8'hA0 + i); in_last = 1'b1;
      #1;
      check("stream_in_ready", 32'(in_ready), 32'h1);
      tick();
      check("stream_out_valid", 32'(out_valid), 32'(4'b0001 << i));
      check("stream_out_data",  32'(out_data),  32'(8'hA0 + i));
    end
    in_valid = 1'b0;
    tick();
    check("stream_drained", 32'(out_valid), 32'h0);

    // Packet lock: head selects channel 2, later selects are ignored.
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h31; in_last = 1'b0;
    tick();
    check("lock_b1_valid", 32'(out_valid), 32'h4);
    check("lock_b1_busy",  32'(busy),      32'h1);
    in_sel = 2'd0; in_data = 8'h32;
    tick();
    check("lock_b2_valid", 32'(out_valid), 32'h4);
    check("lock_b2_data",  32'(out_data),  32'h32);
    in_sel = 2'd3; in_data = 8'h33; in_last = 1'b1;
    tick();
    check("lock_b3_valid", 32'(out_valid), 32'h4);
    check("lock_b3_last",  32'(out_last),  32'h1);
    check("lock_b3_busy",  32'(busy),      32'h0);
    in_valid = 1'b0;
    tick();

    // Backpressure on channel 1; other readies stay high and must be ignored.
    out_ready = 4'b1101;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h11; in_last = 1'b0;
    tick();
    in_sel = 2'd0; in_data = 8'h22; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", 32'(in_ready), 32'h0);
      tick();
      check("bp_out_valid", 32'(out_valid), 32'h2);
      check("bp_out_data",  32'(out_data),  32'h11);
    end
    out_ready = 4'hF;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'h1);
    tick();
    check("bp_b2_valid", 32'(out_valid), 32'h2);
    check("bp_b2_data",  32'(out_data),  32'h22);
    check("bp_b2_last",  32'(out_last),  32'h1);
    in_valid = 1'b0;
    tick();
    check("bp_drained", 32'(out_valid), 32'h0);

    // Drop: channel 2 disabled at the head; re-enabling mid-packet has no effect.
    en_mask = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_sel = 2'd2; in_data = 8'(8'h40 + i); in_last = (i == 3);
      #1;
      check("drop_in_ready", 32'(in_ready), 32'h1);
      tick();
      check("drop_out_valid", 32'(out_valid), 32'h0);
      if (i == 0) en_mask = 4'hF;
    end
    in_valid = 1'b0;
    check("drop_cnt_4", 32'(drop_cnt), 32'h4);
    check("drop_busy",  32'(busy),     32'h0);

    // Out-of-range select on the 3-channel instance, and counter saturation at 3.
    for (int i = 1; i <= 5; i++) begin
      in_valid3 = 1'b1; in_sel = 2'd3; in_data = 8'h77; in_last = 1'b1;
      #1;
      check("oor_in_ready", 32'(in_ready3), 32'h1);
      tick();
      check("oor_out_valid", 32'(out_valid3), 32'h0);
      check("oor_drop_cnt",  32'(drop_cnt3),  32'((i > 3) ? 3 : i));
    end
    in_sel = 2'd2; in_data = 8'h5A;
    tick();
    check("ch3_legal_valid", 32'(out_valid3), 32'h4);
    check("ch3_legal_data",  32'(out_data3),  32'h5A);
    check("ch3_sat_hold",    32'(drop_cnt3),  32'h3);
    in_valid3 = 1'b0;
    tick();

    // Reset mid-packet with a full output register that cannot drain.
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h51; in_last = 1'b0;
    tick();
    in_data = 8'h52;
    tick();
    out_ready = 4'b1101; in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_out_valid", 32'(out_valid), 32'h0);
    check("mrst_busy",      32'(busy),      32'h0);
    check("mrst_drop_cnt",  32'(drop_cnt),  32'h0);
    out_ready = 4'hF;
    in_valid = 1'b1; in_sel = 2'd3; in_data = 8'h5F; in_last = 1'b0;
    tick();
    check("mrst_head_valid", 32'(out_valid), 32'h8);
    check("mrst_head_busy",  32'(busy),      32'h1);
    in_sel = 2'd0; in_data = 8'h60; in_last = 1'b1;
    tick();
    check("mrst_tail_valid", 32'(out_valid), 32'h8);
    check("mrst_tail_data",  32'(out_data),  32'h60);
    in_valid = 1'b0;
    tick();

    // 8-beat packet to channel 0 with a toggling ready: every beat once, in order.
    pat = 16'b1101_0111_0110_1101;
    n_sent = 0; n_recv = 0; cyc = 0;
    while (n_recv < 8 && cyc < 40) begin
      in_valid  = (n_sent < 8);
      in_sel    = 2'd0;
      in_data   = 8'(8'h80 + n_sent);
      in_last   = (n_sent == 7);
      out_ready = {3'b111, pat[cyc % 16]};
      #1;
      acc = in_valid && in_ready;
      if (out_valid[0] && out_ready[0]) begin
        check("da_data", 32'(out_data), 32'(8'h80 + n_recv));
        check("da_last", 32'(out_last), 32'(n_recv == 7));
        n_recv++;
      end
      tick();
      if (acc) n_sent++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 4'hF;
    check("da_sent",  32'(n_sent), 32'h8);
    check("da_recv",  32'(n_recv), 32'h8);
    tick();
    check("da_drained", 32'(out_valid), 32'h0);
    check("da_busy",    32'(busy),      32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stream_demux_n.md
# stream_demux_n

Parametrised, registered 1:N stream demultiplexer with valid/ready handshakes. It is the next step beyond the combinational 1:4 demultiplexer. It routes whole packets from one input stream to one of NUM_CH output channels, and locks the selection for the duration of a packet. Beats for disabled or out-of-range channels are dropped and counted. It sits between a single packet source and per-channel consumers, such as per-port FIFOs.

## Interface
- DATA_W, 8, payload width in bits
- NUM_CH, 4, number of output channels, 2..16
- SEL_W, $clog2(NUM_CH), width of the channel select
- CNT_W, 16, width of the drop counter
- clk  in  1  rising-edge clock
- rst  in  1  reset: synchronous, active-high
- en_mask  in  NUM_CH  per-channel enable; bit i=1 enables channel i
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  DATA_W  input payload
- in_sel  in  SEL_W  target channel; sampled on the first beat of a packet only
- in_last  in  1  last beat of packet
- out_valid  out  NUM_CH  one-hot (or zero) valid per channel
- out_ready  in  NUM_CH  per-channel ready
- out_data  out  DATA_W  shared payload bus for all channels
- out_last  out  1  shared last flag
- busy  out  1  a packet is in progress (state LOCKED)
- drop_cnt  out  CNT_W  number of dropped beats, saturating

## Operation
- A single output register holds the fields reg_v, reg_ch, reg_data and reg_last.
- out_valid[i] = reg_v && (reg_ch == i). out_data = reg_data and out_last = reg_last at all times.
- FSM states:
  - IDLE: the next accepted beat is a packet head.
    - At the head, the channel is ch = in_sel and drop = (in_sel >= NUM_CH) || !en_mask[in_sel].
    - If !in_last, go to LOCKED with lock_ch = ch and lock_drop = drop.
  - LOCKED: in_sel and en_mask are ignored. Beats use lock_ch and lock_drop. An accepted beat with in_last returns the FSM to IDLE.
- Changing en_mask mid-packet has no effect until the next packet head.
- The current drop flag is drop in IDLE and lock_drop in LOCKED. The current channel is ch in IDLE and lock_ch in LOCKED.
- Drop path (current drop flag = 1):
  - in_ready = 1.
  - An accepted beat does not touch the output register.
  - drop_cnt increments by 1 and saturates at 2^CNT_W-1.
- Forward path: in_ready = !reg_v || out_ready[reg_ch]. This is combinational, so a full beat every cycle is possible.
  - Accept: load the register with the beat and reg_ch = current channel; set reg_v = 1.
  - Drain without accept: clear reg_v when out_ready[reg_ch].
  - Drain and accept in the same cycle: reload the register. reg_v stays 1.
- busy = (state == LOCKED).
- A single-beat packet (in_last on the head) never leaves IDLE.

## Timing
- Reset values:
  - state IDLE, reg_v 0, reg_ch 0, reg_data 0, reg_last 0.
  - out_valid all 0, out_data 0, out_last 0.
  - busy 0, drop_cnt 0, lock_ch 0, lock_drop 0.
- Latency: a beat accepted at edge k appears on out_valid[ch] after edge k.
- Throughput: 1 beat/cycle while the target's out_ready is held high.
- Backpressure: once asserted, out_valid/out_data/out_last are held stable until out_ready[reg_ch] is high.
- Ready from non-targeted channels is ignored.
- Reset mid-packet: on the reset edge, the FSM returns to IDLE and the buffered beat is discarded (reg_v = 0). The next accepted beat is treated as a new head.
- in_ready is a function of state, in_sel (IDLE), en_mask (IDLE), reg_v, reg_ch and out_ready. It does not depend on in_valid.

## Test plan
- Reset, en_mask=4'b1111, all out_ready=1:
  - Stimulus: stream single-beat packets with in_sel 0,1,2,3 and data 8'hA0..8'hA3, back to back.
  - Required: out_valid 0001, 0010, 0100, 1000 on consecutive cycles with matching data, one cycle after each accept; in_ready stays 1.
- Packet lock:
  - Stimulus: 3-beat packet with in_sel=2 on the head; in_sel changes to 0 and then 3 on beats 2 and 3.
  - Required: all three beats go to channel 2; busy=1 after beat 1 and 0 after beat 3.
- Backpressure:
  - Stimulus: out_ready[1]=0 for 3 cycles while packet data 8'h11, 8'h22 targets channel 1.
  - Required: out_data holds 8'h11 and in_ready=0 for those cycles; both beats are delivered in order once ready rises.
- Drop:
  - Stimulus: en_mask=4'b1011; send a 4-beat packet to channel 2.
  - Required: in_ready=1 throughout, out_valid stays 0, drop_cnt=4.
  - Stimulus: then set NUM_CH=3 and send in_sel=3.
  - Required: the beat is dropped.
  - Stimulus: preload drop_cnt at 16'hFFFF.
  - Required: drop_cnt stays 16'hFFFF.
- Reset mid-packet:
  - Stimulus: assert rst after beat 2 of a 4-beat packet to channel 1, with the output register full.
  - Required: next cycle out_valid=0, busy=0, drop_cnt=0; the next beat with in_sel=3 routes to channel 3.
- Simultaneous drain/accept:
  - Stimulus: 8-beat packet to channel 0 with out_ready[0] toggling 1,0,1,1,…
  - Required: no beat is lost or duplicated, order is preserved, and out_last is set only with beat 8.
